// File: rtl/pmem_line_responder.sv
// pmem_line_responder
// Bridges the 128-bit cache-line pmem protocol onto a narrow, ready-handshaked
// word memory. A line is moved as BEATS word transactions. Completion is
// signalled by a one-cycle pmem_resp.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for pmem_read / pmem_write (write wins if both)
// RD_BEAT | reading word 'beat' of the line from the backend
// WR_BEAT | writing word 'beat' of the line to the backend
// RESP    | pmem_resp pulse; forced dead cycle before the next accept
module pmem_line_responder #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int WORD_W = 16,
  localparam int BEATS = LINE_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WSH    = $clog2(WORD_W / 8);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_BEAT = 2'd1;
  localparam logic [1:0] WR_BEAT = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_off;

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign beat_off  = ADDR_W'(beat_q) << WSH;

  // Next-state, beat counter and line/data latches.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    line_addr_d = line_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (pmem_write) begin
          line_addr_d = {pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d     = pmem_wdata;
          beat_d      = '0;
          state_d     = WR_BEAT;
        end else if (pmem_read) begin
          line_addr_d = {pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          beat_d      = '0;
          state_d     = RD_BEAT;
        end
      end
      RD_BEAT: begin
        if (mem_ready) begin
          rdata_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) state_d = RESP;
        end
      end
      WR_BEAT: begin
        if (mem_ready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any line in flight and clears the read line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      line_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_addr_q <= line_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Outputs decode straight from registered state so a reset drops the strobes at once.
  assign mem_read   = (state_q == RD_BEAT);
  assign mem_write  = (state_q == WR_BEAT);
  assign pmem_resp  = (state_q == RESP);
  assign mem_addr   = (mem_read || mem_write) ? (line_addr_q + beat_off) : '0;
  assign mem_wdata  = mem_write ? wdata_q[beat_q*WORD_W +: WORD_W] : '0;
  assign pmem_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: backend word model with programmable stall,
// scoreboard of expected word beats and expected read lines.
module tb_pmem_line_responder;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_addr;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_ready;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t        exp_q[$];
  logic [127:0] exp_line;
  int           n_checks;
  int           n_fail;
  int           cyc;
  int           stall_cfg;
  int           wcnt;

  pmem_line_responder dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a[15:8] == 8'h01) return 16'h1000 + ((a - 16'h0120) >> 1);
    return {a[7:0], ~a[15:8]};
  endfunction

  always_comb mem_rdata = mem_read ? word_at(mem_addr) : 16'h0000;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Backend: stalls stall_cfg cycles per word, then accepts and scores the beat.
  initial begin
    beat_t b;
    mem_ready = 0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        check("strobe_excl", {127'b0, mem_read && mem_write}, 128'd0);
        if (wcnt < stall_cfg) begin
          mem_ready = 0;
          wcnt++;
        end else begin
          mem_ready = 1;
          wcnt = 0;
          check("beat_expected", {127'b0, exp_q.size() != 0}, 128'd1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("beat_dir", {127'b0, mem_write}, {127'b0, b.wr});
            check("beat_addr", {112'b0, mem_addr}, {112'b0, b.addr});
            if (b.wr) check("beat_wdata", {112'b0, mem_wdata}, {112'b0, b.data});
          end
        end
      end else begin
        mem_ready = 0;
        wcnt = 0;
      end
    end
  end

  task automatic do_line(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [127:0] wd, input int exp_lat);
    logic [15:0] la;
    int          req_c;
    bit          seen;
    beat_t       b;
    @(negedge clk);
    la = {addr[15:4], 4'h0};
    for (int k = 0; k < 8; k++) begin
      b.wr   = wr;
      b.addr = la + 16'(2 * k);
      b.data = wr ? wd[16*k +: 16] : word_at(b.addr);
      exp_q.push_back(b);
      if (!wr && rd) exp_line[16*k +: 16] = word_at(b.addr);
    end
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    req_c        = cyc;
    seen         = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        seen = 1;
        break;
      end
    end
    check("resp_seen", {127'b0, seen}, 128'd1);
    check("resp_latency", 128'(cyc - req_c), 128'(exp_lat));
    check("rdata", pmem_rdata, exp_line);
    check("beats_done", 128'(exp_q.size()), 128'd0);
    pmem_read  = 0;
    pmem_write = 0;
    @(negedge clk);
    check("resp_one_cycle", {127'b0, pmem_resp}, 128'd0);
    exp_q.delete();
  endtask

  initial begin
    int strobes;
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    stall_cfg    = 0;
    exp_line     = '0;
    pmem_read    = 0;
    pmem_write   = 0;
    pmem_address = '0;
    pmem_wdata   = '0;
    rst          = 0;
    #2 rst = 1;
    #1;
    check("rst_resp", {127'b0, pmem_resp}, 128'd0);
    check("rst_strobes", {126'b0, mem_read, mem_write}, 128'd0);
    check("rst_addr", {112'b0, mem_addr}, 128'd0);
    check("rst_wdata", {112'b0, mem_wdata}, 128'd0);
    check("rst_rdata", pmem_rdata, 128'd0);
    repeat (2) @(negedge clk);
    rst = 0;

    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_read || mem_write) strobes++;
    end
    check("idle_no_strobe", 128'(strobes), 128'd0);

    // zero-wait line read
    do_line(1, 0, 16'h0127, '0, 9);
    check("read_line_value", pmem_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

    // line write, two wait cycles per beat; read line must be untouched
    stall_cfg = 2;
    do_line(0, 1, 16'h0A40, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 25);
    check("write_keeps_rdata", pmem_rdata, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    stall_cfg = 0;

    // back-to-back reads, second issued right after the first resp
    do_line(1, 0, 16'h0150, '0, 9);
    do_line(1, 0, 16'h0B3C, '0, 9);

    // both requests high: write only
    do_line(1, 1, 16'h0170, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 9);

    // reset in the middle of a read, after beat 3 completes
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      b.wr   = 0;
      b.addr = 16'h0300 + 16'(2 * k);
      b.data = word_at(b.addr);
      exp_q.push_back(b);
    end
    pmem_read    = 1;
    pmem_address = 16'h0300;
    repeat (5) @(posedge clk);
    #2 rst = 1;
    pmem_read = 0;
    #1;
    check("midrst_read_low", {127'b0, mem_read}, 128'd0);
    check("midrst_rdata", pmem_rdata, 128'd0);
    check("midrst_resp", {127'b0, pmem_resp}, 128'd0);
    check("midrst_beats_seen", 128'(exp_q.size()), 128'd4);
    exp_q.delete();
    exp_line = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_read || mem_write || pmem_resp) strobes++;
    end
    check("midrst_quiet", 128'(strobes), 128'd0);

    do_line(1, 0, 16'h014A, '0, 9);
    check("post_rst_line", pmem_rdata, 128'h1017_1016_1015_1014_1013_1012_1011_1010);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
